// File: rtl/prime_window_tally.sv
// prime_window_tally: counts samples, flagged primes and flag-vs-golden
// mismatches over a window of WINDOW accepted samples (or a shorter window
// closed by flush), then holds a report until the downstream consumes it.
module prime_window_tally #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_value,
  input  logic             in_prime,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_total,
  output logic [CNT_W-1:0] out_prime_cnt,
  output logic [CNT_W-1:0] out_mismatch,
  output logic [2:0]       out_last_prime
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  // Reference primality for the 3-bit sample range.
  function automatic logic golden_prime(input logic [2:0] v);
    case (v)
      3'd2, 3'd3, 3'd5, 3'd7: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Running window accumulators.
  logic [CNT_W-1:0] acc_total_p0;
  logic [CNT_W-1:0] acc_prime_p0;
  logic [CNT_W-1:0] acc_mis_p0;
  logic [2:0]       acc_last_p0;

  logic             accept;
  logic [CNT_W-1:0] inc_total;
  logic [CNT_W-1:0] inc_prime;
  logic [CNT_W-1:0] inc_mis;
  logic [2:0]       inc_last;
  logic             window_full;
  logic             enter_report;

  assign in_ready = (state != REPORT);
  assign accept   = in_valid && in_ready;

  // Accumulator values as they would be after including the current sample.
  always_comb begin
    inc_total   = sat_inc(acc_total_p0, 1'b1);
    inc_prime   = sat_inc(acc_prime_p0, in_prime);
    inc_mis     = sat_inc(acc_mis_p0, in_prime ^ golden_prime(in_value));
    inc_last    = in_prime ? in_value : acc_last_p0;
    window_full = (inc_total == CNT_W'(WINDOW));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: a window closes when it fills or on flush with data held.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = (window_full || flush) ? REPORT : ACCUM;
      end
      ACCUM: begin
        if (flush || (accept && window_full))
          state_nxt = REPORT;
      end
      REPORT: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_report = (state != REPORT) && (state_nxt == REPORT);

  // Accumulate accepted samples, capture the report on window close, and
  // clear it once the downstream has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_total_p0   <= '0;
      acc_prime_p0   <= '0;
      acc_mis_p0     <= '0;
      acc_last_p0    <= '0;
      out_valid      <= 1'b0;
      out_total      <= '0;
      out_prime_cnt  <= '0;
      out_mismatch   <= '0;
      out_last_prime <= '0;
    end else if (enter_report) begin
      // A flush without a sample this edge reports the counts already held.
      out_valid      <= 1'b1;
      out_total      <= accept ? inc_total : acc_total_p0;
      out_prime_cnt  <= accept ? inc_prime : acc_prime_p0;
      out_mismatch   <= accept ? inc_mis   : acc_mis_p0;
      out_last_prime <= accept ? inc_last  : acc_last_p0;
      acc_total_p0   <= '0;
      acc_prime_p0   <= '0;
      acc_mis_p0     <= '0;
      acc_last_p0    <= '0;
    end else if (state == REPORT) begin
      if (out_ready) begin
        out_valid      <= 1'b0;
        out_total      <= '0;
        out_prime_cnt  <= '0;
        out_mismatch   <= '0;
        out_last_prime <= '0;
      end
    end else if (accept) begin
      acc_total_p0 <= inc_total;
      acc_prime_p0 <= inc_prime;
      acc_mis_p0   <= inc_mis;
      acc_last_p0  <= inc_last;
    end
  end

endmodule

// File: tb/tb_prime_window_tally.sv
// Testbench for prime_window_tally (WINDOW=8, CNT_W=4): table-driven windows
// with a report scoreboard, plus directed handshake, flush and reset sequences.
module tb_prime_window_tally;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_value;
  logic             in_prime;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_total;
  logic [CNT_W-1:0] out_prime_cnt;
  logic [CNT_W-1:0] out_mismatch;
  logic [2:0]       out_last_prime;

  prime_window_tally #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .in_prime      (in_prime),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_total     (out_total),
    .out_prime_cnt (out_prime_cnt),
    .out_mismatch  (out_mismatch),
    .out_last_prime(out_last_prime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tot;
    int pcnt;
    int mis;
    int last;
  } rep_t;

  // fmode: 0 = window closes by count, 1 = flush with last sample,
  //        2 = flush alone on the cycle after the last sample.
  typedef struct {
    logic [23:0] vals;
    logic [7:0]  pmask;
    int          n;
    int          fmode;
    rep_t        exp;
  } vec_t;

  rep_t sbq[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present one sample and hold it until the DUT accepts it.
  task automatic send(input logic [2:0] v, input logic p, input logic f);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_prime = p;
    flush    = f;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0d expected=1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_ascending();
    for (int v = 0; v < 8; v++)
      send(3'(v), (v == 2 || v == 3 || v == 5 || v == 7), 1'b0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_total", out_total, 0);
    chk("rst_out_prime_cnt", out_prime_cnt, 0);
    chk("rst_out_mismatch", out_mismatch, 0);
    chk("rst_out_last_prime", out_last_prime, 0);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard: every consumed report must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report total=%0d expected=no report", out_total);
      end else begin
        rep_t r;
        r = sbq.pop_front();
        chk("rep_total", out_total, r.tot);
        chk("rep_prime_cnt", out_prime_cnt, r.pcnt);
        chk("rep_mismatch", out_mismatch, r.mis);
        chk("rep_last_prime", out_last_prime, r.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t expected=finish", $time);
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_prime  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    tbl[0] = '{{3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 8'hAC, 8, 0, '{8, 4, 0, 7}};
    tbl[1] = '{{3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 8'h9C, 8, 0, '{8, 4, 2, 7}};
    tbl[2] = '{{3'd0,3'd0,3'd0,3'd0,3'd6,3'd4,3'd1,3'd1}, 8'h00, 4, 2, '{4, 0, 0, 0}};
    tbl[3] = '{{3'd0,3'd0,3'd0,3'd0,3'd0,3'd5,3'd3,3'd2}, 8'h07, 3, 1, '{3, 3, 0, 5}};
    tbl[4] = '{{3'd6,3'd2,3'd4,3'd0,3'd1,3'd7,3'd7,3'd7}, 8'hFF, 8, 0, '{8, 8, 4, 6}};
    tbl[5] = '{{3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd5}, 8'h00, 1, 1, '{1, 0, 1, 0}};

    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 1);
    chk("init_out_total", out_total, 0);
    chk("init_out_last_prime", out_last_prime, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven windows.
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(tbl[i].exp);
      for (int j = 0; j < tbl[i].n; j++)
        send(tbl[i].vals[3*j +: 3], tbl[i].pmask[j],
             (tbl[i].fmode == 1) && (j == tbl[i].n - 1));
      if (tbl[i].fmode == 2) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("no_report_before_flush", out_valid, 0);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_report_valid", out_valid, 1);
      end else begin
        idle_inputs();
        chk("report_latency", out_valid, 1);
      end
    end

    // Flush with an empty window must not produce a report.
    repeat (2) idle_inputs();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("idle_flush_no_valid", out_valid, 0);
    chk("idle_flush_in_ready", in_ready, 1);
    @(negedge clk);
    chk("idle_flush_no_valid_2", out_valid, 0);

    // Backpressure: report held with out_ready low, no acceptance meanwhile.
    out_ready = 1'b0;
    sbq.push_back('{8, 4, 0, 7});
    send_ascending();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_value = 3'd3;
      in_prime = 1'b1;
      flush    = 1'b1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_total", out_total, 8);
      chk("hold_prime_cnt", out_prime_cnt, 4);
      chk("hold_last_prime", out_last_prime, 7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);

    // Reset in the middle of a partial window; the next window starts fresh.
    send(3'd1, 1'b0, 1'b0);
    send(3'd2, 1'b1, 1'b0);
    send(3'd3, 1'b1, 1'b0);
    idle_inputs();
    pulse_reset();
    sbq.push_back('{8, 4, 0, 7});
    send_ascending();
    idle_inputs();
    chk("post_reset_latency", out_valid, 1);

    // Reset while a report is pending discards it.
    @(negedge clk);
    out_ready = 1'b0;
    send_ascending();
    idle_inputs();
    chk("pending_report_valid", out_valid, 1);
    pulse_reset();
    out_ready = 1'b1;
    sbq.push_back('{1, 1, 0, 2});
    send(3'd2, 1'b1, 1'b1);
    idle_inputs();
    chk("fresh_single_latency", out_valid, 1);

    for (int k = 0; k < 20 && sbq.size() != 0; k++)
      @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
